// File: rtl/alu_issue_unit.sv
// Command-driven issue/writeback front end for the combinational ALU.
// Holds the register file and architectural flags; one command in flight at a time.
//
// state | meaning
// IDLE  | ready for a command; latches it on cmd_valid
// EXEC  | ALU inputs driven from latched sources; result/flags sampled at end of cycle
// WB    | result (or immediate) written to rd, flags updated for ALU ops, rsp_valid high
module alu_issue_unit #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 4,
  parameter int OP_W   = 3,
  parameter int NREG   = 4,
  parameter int RIDX_W = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [RIDX_W-1:0] cmd_rd,
  input  logic [RIDX_W-1:0] cmd_ra,
  input  logic [RIDX_W-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FLAG_W-1:0] alu_flags_in,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_z,
  input  logic [FLAG_W-1:0] alu_flags_out,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [FLAG_W-1:0] flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              c_load;
  logic [OP_W-1:0]   c_op;
  logic [RIDX_W-1:0] c_rd;
  logic [RIDX_W-1:0] c_ra;
  logic [RIDX_W-1:0] c_rb;
  logic [DATA_W-1:0] c_imm;

  logic [DATA_W-1:0] res_z;
  logic [FLAG_W-1:0] res_flags;

  logic [DATA_W-1:0] rf [NREG];
  logic [FLAG_W-1:0] flags_q;

  logic              accept;
  logic [DATA_W-1:0] wb_data;
  logic [FLAG_W-1:0] wb_flags;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = cmd_load ? S_WB : S_EXEC;
        end
      end
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Loads bypass the ALU and keep the current flags.
  always_comb begin
    cmd_ready     = (state == S_IDLE) && !reset;
    rsp_valid     = (state == S_WB);
    wb_data       = c_load ? c_imm : res_z;
    wb_flags      = c_load ? flags_q : res_flags;
    rsp_data      = wb_data;
    rsp_flags     = wb_flags;
    alu_a         = rf[c_ra];
    alu_b         = rf[c_rb];
    alu_flags_in  = flags_q;
    alu_operation = c_op;
    flags         = flags_q;
  end

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      c_load    <= 1'b0;
      c_op      <= '0;
      c_rd      <= '0;
      c_ra      <= '0;
      c_rb      <= '0;
      c_imm     <= '0;
      res_z     <= '0;
      res_flags <= '0;
      flags_q   <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (accept) begin
        c_load <= cmd_load;
        c_op   <= cmd_op;
        c_rd   <= cmd_rd;
        c_ra   <= cmd_ra;
        c_rb   <= cmd_rb;
        c_imm  <= cmd_imm;
      end
      if (state == S_EXEC) begin
        res_z     <= alu_z;
        res_flags <= alu_flags_out;
      end
      // Write commits at the end of WB, so a command accepted next sees it in EXEC.
      if (state == S_WB) begin
        rf[c_rd] <= wb_data;
        flags_q  <= wb_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU on the alu_* ports, an in-order
// register/flags model, and a cycle-exact response scoreboard.
module tb_alu_issue_unit;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_z;
  logic [3:0] alu_flags_in, alu_flags_out;
  logic [2:0] alu_operation;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  alu_issue_unit dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_flags_in(alu_flags_in),
    .alu_operation(alu_operation), .alu_z(alu_z), .alu_flags_out(alu_flags_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .flags(flags)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Environment ALU: flags = {carry, sign, 0, 1}; op 5 adds carry-in from flags[3].
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] fin, input logic [2:0] op);
    logic [8:0] s;
    case (op)
      3'd0: s = {1'b0, a} + {1'b0, b};
      3'd1: s = {1'b0, a} - {1'b0, b};
      3'd2: s = {1'b0, a & b};
      3'd3: s = {1'b0, a | b};
      3'd4: s = {1'b0, a ^ b};
      3'd5: s = {1'b0, a} + {1'b0, b} + {8'd0, fin[3]};
      3'd6: s = {1'b0, a ^ {fin, fin}};
      default: s = {1'b0, ~a};
    endcase
    return {s[8], s[7], 1'b0, 1'b1, s[7:0]};
  endfunction

  always_comb {alu_flags_out, alu_z} = alu_fn(alu_a, alu_b, alu_flags_in, alu_operation);

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic [3:0] f;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] m_regs [4];
  logic [3:0] m_flags   = '0;
  logic [3:0] vis_flags = '0;
  int         busy_until = -1;
  bit         pend_exec  = 0;
  logic [7:0] ex_a, ex_b;
  logic [3:0] ex_f;
  logic [2:0] ex_op;

  always @(negedge clock) begin
    logic [11:0] r;
    rsp_t        e;
    bit          rsp_now;
    if (cyc >= 1) begin
      if (reset) begin
        check("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_flags    = '0;
        vis_flags  = '0;
        exp_q.delete();
        pend_exec  = 0;
        busy_until = cyc;
      end else begin
        if (pend_exec) begin
          check("exec_alu_a", {24'd0, alu_a}, {24'd0, ex_a});
          check("exec_alu_b", {24'd0, alu_b}, {24'd0, ex_b});
          check("exec_flags_in", {28'd0, alu_flags_in}, {28'd0, ex_f});
          check("exec_op", {29'd0, alu_operation}, {29'd0, ex_op});
          pend_exec = 0;
        end
        rsp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, rsp_now});
        if (rsp_now) begin
          check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q[0].d});
          check("rsp_flags", {28'd0, rsp_flags}, {28'd0, exp_q[0].f});
        end
        check("flags", {28'd0, flags}, {28'd0, vis_flags});
        if (rsp_now) begin
          vis_flags = exp_q[0].f;
          void'(exp_q.pop_front());
        end
        check("cmd_ready", {31'd0, cmd_ready}, {31'd0, (cyc > busy_until)});
        if (cmd_valid && cmd_ready) begin
          if (cmd_load) begin
            e.d   = cmd_imm;
            e.f   = m_flags;
            e.cyc = cyc + 1;
          end else begin
            ex_a  = m_regs[cmd_ra];
            ex_b  = m_regs[cmd_rb];
            ex_f  = m_flags;
            ex_op = cmd_op;
            pend_exec = 1;
            r     = alu_fn(ex_a, ex_b, ex_f, ex_op);
            e.d   = r[7:0];
            e.f   = r[11:8];
            e.cyc = cyc + 2;
          end
          m_regs[cmd_rd] = e.d;
          m_flags        = e.f;
          busy_until     = e.cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Drives one command and waits (bounded) for its acceptance; returns the accept cycle.
  task automatic issue(input bit load, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                       input bit hold, output int acc);
    bit ok;
    cmd_load  = load;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_ra    = ra;
    cmd_rb    = rb;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    ok  = 0;
    acc = -1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok  = 1;
        acc = cyc;
      end
    end
    if (!ok) check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clock);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  initial begin
    int acc, prev;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_ra    = '0;
    cmd_rb    = '0;
    cmd_imm   = '0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check("rst_alu_op", {29'd0, alu_operation}, 32'd0);
    check("rst_rsp", {20'd0, rsp_valid, rsp_data, rsp_flags}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);

    issue(1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h12, 0, acc);
    issue(1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h34, 0, acc);
    issue(0, 3'd0, 2'd0, 2'd1, 2'd2, 8'h00, 0, acc);
    repeat (3) @(negedge clock);
    check("dir_flags_after_add", {28'd0, flags}, 32'h1);
    issue(0, 3'd5, 2'd1, 2'd0, 2'd0, 8'h00, 0, acc);
    repeat (3) @(negedge clock);

    prev = -1;
    for (int i = 0; i < 6; i++) begin
      issue(0, 3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom), 8'h00, 1, acc);
      if (prev >= 0) check("b2b_alu_gap", acc - prev, 32'd3);
      prev = acc;
    end
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      issue(1, 3'd0, 2'($urandom), 2'd0, 2'd0, 8'($urandom), 1, acc);
      if (prev >= 0) check("b2b_load_gap", acc - prev, 32'd2);
      prev = acc;
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);

    issue(1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h55, 0, acc);
    issue(0, 3'd3, 2'd2, 2'd2, 2'd1, 8'h00, 0, acc);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_flags", {28'd0, flags}, 32'd0);
    issue(0, 3'd4, 2'd1, 2'd2, 2'd2, 8'h00, 0, acc);
    repeat (3) @(negedge clock);

    issue(1, 3'd0, 2'd3, 2'd0, 2'd0, 8'h80, 0, acc);
    issue(0, 3'd0, 2'd3, 2'd3, 2'd3, 8'h00, 0, acc);
    repeat (3) @(negedge clock);
    check("alias_flags", {28'd0, flags}, 32'h9);
    issue(0, 3'd3, 2'd0, 2'd3, 2'd3, 8'h00, 0, acc);

    for (int i = 0; i < 150; i++) begin
      issue(($urandom_range(0, 2) == 0), 3'($urandom), 2'($urandom), 2'($urandom),
            2'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), acc);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clock);
        #1;
      end
    end
    cmd_valid = 1'b0;
    repeat (6) @(negedge clock);
    check("drain_pending", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Command-driven front end for the combinational ALU. It accepts register-level commands over a valid/ready handshake and holds a small register file plus the architectural flags register. It drives the ALU operand, flag and operation inputs, captures the ALU result and flags one cycle later, writes both back, and reports each completed command on a response port. It sits directly upstream and downstream of the ALU: its `alu_*` outputs feed the ALU inputs, and the ALU outputs return to its `alu_z`/`alu_flags_out` inputs.

## Interface
- `DATA_W`, 8, ALU operand/result width
- `FLAG_W`, 4, ALU flag vector width
- `OP_W`, 3, ALU operation code width
- `NREG`, 4, register-file depth (power of two); `RIDX_W` = log2(`NREG`)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  unit can accept a command
- `cmd_load`  in  1  1 = load immediate into `cmd_rd`; 0 = ALU operation
- `cmd_op`  in  `OP_W`  ALU operation code (ignored for loads)
- `cmd_rd`  in  `RIDX_W`  destination register
- `cmd_ra`, `cmd_rb`  in  `RIDX_W`  source registers for A and B
- `cmd_imm`  in  `DATA_W`  immediate for loads
- `alu_a`, `alu_b`  out  `DATA_W`  to ALU A/B
- `alu_flags_in`  out  `FLAG_W`  to ALU flags_in
- `alu_operation`  out  `OP_W`  to ALU operation
- `alu_z`  in  `DATA_W`  from ALU Z
- `alu_flags_out`  in  `FLAG_W`  from ALU flags_out
- `rsp_valid`  out  1  one-cycle pulse per completed command
- `rsp_data`  out  `DATA_W`  value written to `rd`
- `rsp_flags`  out  `FLAG_W`  flags register value after the command
- `flags`  out  `FLAG_W`  current architectural flags register

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE: `cmd_ready`=1. When `cmd_valid`=1, latch the command into the command register. An ALU command goes to EXEC; a load goes directly to WB.
- EXEC: `alu_a` = reg[ra], `alu_b` = reg[rb], `alu_flags_in` = `flags`, `alu_operation` = latched op. At the end of the cycle, sample `alu_z`/`alu_flags_out` into the result register, then go to WB.
- WB: write the result (or the immediate, for a load) to reg[rd]. An ALU command also updates `flags` from the sampled flags; a load leaves `flags` unchanged. Assert `rsp_valid` with `rsp_data`/`rsp_flags` = the post-write values. Return to IDLE.
- `cmd_ready`=0 in EXEC and WB, and in any cycle where `reset`=1. `cmd_valid` seen while not ready is ignored; the source must hold it.
- `ra`, `rb` and `rd` may alias; sources are read in EXEC, before the WB write.
- Result and flags are truncated to `DATA_W`/`FLAG_W`; the unit performs no arithmetic of its own.
- `alu_*` outputs are driven from the command register and the register file in every state; the ALU result is used only when sampled in EXEC.

## Timing
- Reset (sync): state IDLE; all registers, `flags`, command register and result register = 0. Therefore `alu_a`/`alu_b`/`alu_flags_in`/`alu_operation` = 0, `rsp_valid`=0, and `rsp_data`/`rsp_flags` = 0.
- ALU command: accepted at edge N (IDLE); EXEC in cycle N+1; `rsp_valid` high in cycle N+2; register/flags update visible from N+3. `cmd_ready` is high again in N+3.
- Load: accepted at N; `rsp_valid` high in N+1; next accept possible at end of N+2.
- Throughput: one ALU command per 3 cycles; one load per 2 cycles.
- Reset asserted in EXEC or WB aborts the command: no write, no `rsp_valid`, and all state is cleared on that edge.
- A command accepted immediately after WB sees the written value (the write commits before the next EXEC).

## Test plan
- Reset hold, then release -> all outputs 0, `cmd_ready`=1 on the first cycle after release.
- Load 0x12 -> r1 and 0x34 -> r2 -> `rsp_valid` pulses with `rsp_data` 0x12, then 0x34; `flags` stays 0.
- ALU command op=0, ra=1, rb=2, rd=0; bench ALU model returns Z=0x46, flags=0x1 -> `alu_a`=0x12 and `alu_b`=0x34 in EXEC; rsp 0x46/0x1 two cycles after accept; next command sees `alu_flags_in`=0x1.
- `cmd_valid` held continuously with back-to-back commands -> acceptances exactly 3 cycles apart; no command is dropped or duplicated.
- Reset pulsed during EXEC -> no `rsp_valid`; reg[rd] and `flags` = 0 afterwards.
- ra=rb=rd=3 with reg3=0x80; model Z = A+B = 0x00, flags=0x9 -> `alu_a`=`alu_b`=0x80; reg3 becomes 0x00.
